// File: rtl/seq_slice_mac_pkg.sv
// Shared types and sizing helpers for the slice-serial multiply-accumulate unit.
package seq_slice_mac_pkg;

  // Operation sequencing: accept, digit-serial multiply, sign fix / accumulate, report.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } state_e;

  // Number of SLICE-bit digits per WIDTH-bit operand.
  function automatic int unsigned num_slices(input int unsigned width, input int unsigned slice);
    return width / slice;
  endfunction

  // Accumulator width: full product plus guard bits.
  function automatic int unsigned acc_width(input int unsigned width, input int unsigned guard);
    return 2 * width + guard;
  endfunction

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_slice_mac_slice_mult.sv
// Combinational SLICE x SLICE unsigned digit multiplier.
module seq_slice_mac_slice_mult
  import seq_slice_mac_pkg::*;
#(
  parameter int unsigned SLICE = 2
) (
  input  logic [SLICE-1:0]   i_x,
  input  logic [SLICE-1:0]   i_y,
  output logic [2*SLICE-1:0] o_p
);

  localparam int unsigned PW = 2 * SLICE;

  // Widen before multiplying so the full digit product is kept.
  always_comb begin
    o_p = PW'(i_x) * PW'(i_y);
  end

endmodule

// File: rtl/seq_slice_mac.sv
// Sequential multiply-accumulate: one digit-pair partial product per cycle, optional
// two's-complement mode, running accumulator with sticky overflow, busy/done handshake.
module seq_slice_mac
  import seq_slice_mac_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SLICE = 2,
  parameter int unsigned GUARD = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_signed_en,
  input  logic                     i_acc_en,
  input  logic                     i_acc_clr,
  input  logic [WIDTH-1:0]         i_a,
  input  logic [WIDTH-1:0]         i_b,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [2*WIDTH-1:0]       o_prod,
  output logic [2*WIDTH+GUARD-1:0] o_acc,
  output logic                     o_ovf
);

  localparam int unsigned S     = num_slices(WIDTH, SLICE);
  localparam int unsigned ACC_W = acc_width(WIDTH, GUARD);
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned NK    = S * S;
  localparam int unsigned KW    = cnt_width(NK);
  localparam logic [KW-1:0] KLast = KW'(NK - 1);

  if ((WIDTH % SLICE) != 0) begin : g_bad_slice
    $error("seq_slice_mac: WIDTH must be a multiple of SLICE");
  end

  state_e             r_state;
  state_e             w_state_nxt;
  logic [WIDTH-1:0]   r_a_mag;
  logic [WIDTH-1:0]   r_b_mag;
  logic               r_neg;
  logic               r_signed;
  logic               r_acc_en;
  logic [KW-1:0]      r_k;
  logic [PW-1:0]      r_sum;
  logic [PW-1:0]      r_prod;
  logic [ACC_W-1:0]   r_acc;
  logic               r_ovf;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [KW-1:0]      w_i;
  logic [KW-1:0]      w_j;
  logic [31:0]        w_a_sh;
  logic [31:0]        w_b_sh;
  logic [31:0]        w_p_sh;
  logic [SLICE-1:0]   w_a_dig;
  logic [SLICE-1:0]   w_b_dig;
  logic [2*SLICE-1:0] w_pp;
  logic [PW-1:0]      w_pp_sh;
  logic [PW-1:0]      w_res;
  logic [ACC_W-1:0]   w_ext;
  logic [ACC_W:0]     w_acc_sum;
  logic               w_ovf_add;

  // Operand magnitudes; -2^(WIDTH-1) negates to itself, which reads correctly as unsigned.
  always_comb begin
    w_a_mag = (i_signed_en && i_a[WIDTH-1]) ? -i_a : i_a;
    w_b_mag = (i_signed_en && i_b[WIDTH-1]) ? -i_b : i_b;
  end

  // Digit indices and shifted digit selection for the current step k.
  always_comb begin
    w_i     = r_k / KW'(S);
    w_j     = r_k % KW'(S);
    w_a_sh  = 32'(w_i) * SLICE;
    w_b_sh  = 32'(w_j) * SLICE;
    w_p_sh  = (32'(w_i) + 32'(w_j)) * SLICE;
    w_a_dig = SLICE'(r_a_mag >> w_a_sh);
    w_b_dig = SLICE'(r_b_mag >> w_b_sh);
    w_pp_sh = PW'(w_pp) << w_p_sh;
  end

  seq_slice_mac_slice_mult #(
    .SLICE(SLICE)
  ) u_slice_mult (
    .i_x(w_a_dig),
    .i_y(w_b_dig),
    .o_p(w_pp)
  );

  // Signed result, its accumulator-width extension, and the overflow of adding it in.
  always_comb begin
    w_res     = r_neg ? -r_sum : r_sum;
    w_ext     = r_signed ? ACC_W'($signed(w_res)) : ACC_W'(w_res);
    w_acc_sum = {1'b0, r_acc} + {1'b0, w_ext};
    if (r_signed) begin
      w_ovf_add = (r_acc[ACC_W-1] == w_ext[ACC_W-1]) &&
                  (w_acc_sum[ACC_W-1] != r_acc[ACC_W-1]);
    end else begin
      w_ovf_add = w_acc_sum[ACC_W];
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: if (i_start) w_state_nxt = StMul;
      StMul:  if (r_k == KLast) w_state_nxt = StFix;
      StFix:  w_state_nxt = StDone;
      StDone: w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    unique case (r_state)
      StMul, StFix: o_busy = 1'b1;
      StDone:       o_done = 1'b1;
      default:      ;
    endcase
  end

  // Datapath: operand latch, partial-sum accumulation, result and accumulator update.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a_mag  <= '0;
      r_b_mag  <= '0;
      r_neg    <= 1'b0;
      r_signed <= 1'b0;
      r_acc_en <= 1'b0;
      r_k      <= '0;
      r_sum    <= '0;
      r_prod   <= '0;
      r_acc    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          // Clear lands at this edge; an accumulate started now only adds in FIX.
          if (i_acc_clr) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
          end
          if (i_start) begin
            r_a_mag  <= w_a_mag;
            r_b_mag  <= w_b_mag;
            r_neg    <= i_signed_en & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_signed <= i_signed_en;
            r_acc_en <= i_acc_en;
            r_k      <= '0;
            r_sum    <= '0;
          end
        end
        StMul: begin
          r_sum <= r_sum + w_pp_sh;
          r_k   <= r_k + KW'(1);
        end
        StFix: begin
          r_prod <= w_res;
          if (r_acc_en) begin
            r_acc <= w_acc_sum[ACC_W-1:0];
            if (w_ovf_add) r_ovf <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_prod = r_prod;
  assign o_acc  = r_acc;
  assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_seq_slice_mac.sv
// Self-checking bench for seq_slice_mac: default 8/2 instance plus 12/3 and 8/8 sweeps.
module tb_seq_slice_mac;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Default instance (WIDTH=8, SLICE=2, GUARD=4).
  logic        start, signed_en, acc_en, acc_clr;
  logic [7:0]  a, b;
  logic        busy, done, ovf;
  logic [15:0] prod;
  logic [19:0] acc;

  // WIDTH=12, SLICE=3 instance.
  logic        start12, signed12;
  logic [11:0] a12, b12;
  logic        busy12, done12, ovf12;
  logic [23:0] prod12;
  logic [27:0] acc12;

  // WIDTH=8, SLICE=8 instance.
  logic        start88, signed88;
  logic [7:0]  a88, b88;
  logic        busy88, done88, ovf88;
  logic [15:0] prod88;
  logic [19:0] acc88;

  seq_slice_mac u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_signed_en(signed_en),
    .i_acc_en(acc_en), .i_acc_clr(acc_clr), .i_a(a), .i_b(b),
    .o_busy(busy), .o_done(done), .o_prod(prod), .o_acc(acc), .o_ovf(ovf)
  );

  seq_slice_mac #(.WIDTH(12), .SLICE(3), .GUARD(4)) u_dut12 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start12), .i_signed_en(signed12),
    .i_acc_en(1'b0), .i_acc_clr(1'b0), .i_a(a12), .i_b(b12),
    .o_busy(busy12), .o_done(done12), .o_prod(prod12), .o_acc(acc12), .o_ovf(ovf12)
  );

  seq_slice_mac #(.WIDTH(8), .SLICE(8), .GUARD(4)) u_dut88 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start88), .i_signed_en(signed88),
    .i_acc_en(1'b0), .i_acc_clr(1'b0), .i_a(a88), .i_b(b88),
    .o_busy(busy88), .o_done(done88), .o_prod(prod88), .o_acc(acc88), .o_ovf(ovf88)
  );

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  logic [15:0] q_prod[$];
  logic [23:0] q12[$];
  logic [15:0] q88[$];
  logic [19:0] m_acc;
  logic        m_ovf;

  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] ref_prod8(input logic [7:0] x, input logic [7:0] y,
                                            input logic s);
    longint px, py;
    px = s ? longint'($signed(x)) : longint'(x);
    py = s ? longint'($signed(y)) : longint'(y);
    return 16'(px * py);
  endfunction

  task automatic model_acc(input logic [15:0] p, input logic s);
    longint cur, add, sum;
    if (s) begin
      cur = longint'($signed(m_acc));
      add = longint'($signed(p));
      sum = cur + add;
      if (sum > 524287 || sum < -524288) m_ovf = 1'b1;
    end else begin
      cur = longint'(m_acc);
      add = longint'(p);
      sum = cur + add;
      if (sum > 1048575) m_ovf = 1'b1;
    end
    m_acc = 20'(sum);
  endtask

  // One operation on the default instance; called right after a posedge (#1).
  task automatic do_op(input string name, input logic [7:0] ta, input logic [7:0] tb,
                       input logic ts, input logic te, input logic tc,
                       input bit keep, input bit disturb);
    int n, busy_n, d0;
    logic [15:0] exp_p;
    a = ta; b = tb; signed_en = ts; acc_en = te; acc_clr = tc; start = 1'b1;
    if (tc) begin
      m_acc = '0;
      m_ovf = 1'b0;
    end
    q_prod.push_back(ref_prod8(ta, tb, ts));
    d0 = done_cnt;
    @(posedge clk); #1;
    if (!keep) start = 1'b0;
    acc_clr = 1'b0;
    n = 0;
    busy_n = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) busy_n++;
      if (disturb && n == 3) begin
        a = ~ta; b = tb + 8'd7; start = 1'b1; acc_clr = 1'b1;
        acc_en = ~te; signed_en = ~ts;
      end
      if (disturb && n == 4) begin
        start = 1'b0; acc_clr = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    exp_p = q_prod.pop_front();
    if (te) model_acc(exp_p, ts);
    total++;
    if (n != 17) begin
      bad++; $display("FAIL %s latency: got %0d edges want 17", name, n);
    end
    total++;
    if (busy_n != 17) begin
      bad++; $display("FAIL %s busy cycles: got %0d want 17", name, busy_n);
    end
    total++;
    if (prod !== exp_p) begin
      bad++; $display("FAIL %s prod: got %h want %h", name, prod, exp_p);
    end
    total++;
    if (acc !== m_acc) begin
      bad++; $display("FAIL %s acc: got %h want %h", name, acc, m_acc);
    end
    total++;
    if (ovf !== m_ovf) begin
      bad++; $display("FAIL %s ovf: got %b want %b", name, ovf, m_ovf);
    end
    @(posedge clk); #1;
    total++;
    if (done_cnt - d0 != 1) begin
      bad++; $display("FAIL %s done pulses: got %0d want 1", name, done_cnt - d0);
    end
  endtask

  task automatic clear_acc(input string name);
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    m_acc = '0;
    m_ovf = 1'b0;
    total++;
    if (acc !== 20'd0 || ovf !== 1'b0) begin
      bad++; $display("FAIL %s clear: got acc=%h ovf=%b want 0/0", name, acc, ovf);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 0; signed_en = 0; acc_en = 0; acc_clr = 0; a = '0; b = '0;
    start12 = 0; signed12 = 0; a12 = '0; b12 = '0;
    start88 = 0; signed88 = 0; a88 = '0; b88 = '0;
    m_acc = '0; m_ovf = 1'b0;
    repeat (3) @(posedge clk); #1;
    total++;
    if ({busy, done, ovf} !== 3'b000) begin
      bad++; $display("FAIL reset flags: got %b want 000", {busy, done, ovf});
    end
    total++;
    if (prod !== 16'd0 || acc !== 20'd0) begin
      bad++; $display("FAIL reset data: got prod=%h acc=%h want 0", prod, acc);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    do_op("u200x150", 8'd200, 8'd150, 1'b0, 1'b0, 1'b0, 0, 0);
    total++;
    if (prod !== 16'h7530) begin
      bad++; $display("FAIL u200x150 const: got %h want 7530", prod);
    end
    do_op("u255x1", 8'd255, 8'd1, 1'b0, 1'b0, 1'b0, 0, 0);
    do_op("u0x77", 8'd0, 8'd77, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_signed();
    do_op("s-3x5", 8'hFD, 8'd5, 1'b1, 1'b0, 1'b0, 0, 0);
    do_op("s-128x-128", 8'h80, 8'h80, 1'b1, 1'b0, 1'b0, 0, 0);
    total++;
    if (prod !== 16'h4000) begin
      bad++; $display("FAIL s-128x-128 const: got %h want 4000", prod);
    end
    do_op("s-128x127", 8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 0, 0);
    total++;
    if (prod !== 16'hC080) begin
      bad++; $display("FAIL s-128x127 const: got %h want c080", prod);
    end
  endtask

  task automatic test_accumulate();
    do_op("acc_u1", 8'd100, 8'd100, 1'b0, 1'b1, 1'b1, 0, 0);
    do_op("acc_u2", 8'd100, 8'd100, 1'b0, 1'b1, 1'b0, 0, 0);
    total++;
    if (acc !== 20'd20000) begin
      bad++; $display("FAIL acc_u2 const: got %0d want 20000", acc);
    end
    clear_acc("wrap_pre");
    for (int i = 0; i < 17; i++) do_op("acc_wrap", 8'd255, 8'd255, 1'b0, 1'b1, 1'b0, 0, 0);
    total++;
    if (acc !== 20'd56849 || ovf !== 1'b1) begin
      bad++; $display("FAIL acc_wrap final: got acc=%0d ovf=%b want 56849/1", acc, ovf);
    end
    do_op("ovf_sticky", 8'd1, 8'd1, 1'b0, 1'b0, 1'b0, 0, 0);
    clear_acc("wrap_post");
    do_op("acc_s1", 8'hFD, 8'd5, 1'b1, 1'b1, 1'b1, 0, 0);
    do_op("acc_s2", 8'hFD, 8'd5, 1'b1, 1'b1, 1'b0, 0, 0);
    total++;
    if (acc !== 20'hFFFE2 || ovf !== 1'b0) begin
      bad++; $display("FAIL acc_s2 const: got acc=%h ovf=%b want fffe2/0", acc, ovf);
    end
    clear_acc("sovf_pre");
    for (int i = 0; i < 32; i++) do_op("acc_sovf", 8'h80, 8'h80, 1'b1, 1'b1, 1'b0, 0, 0);
    clear_acc("sovf_post");
  endtask

  task automatic test_handshake();
    do_op("disturb", 8'd37, 8'd91, 1'b0, 1'b0, 1'b0, 0, 1);
    do_op("b2b_first", 8'd12, 8'd13, 1'b0, 1'b0, 1'b0, 1, 0);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL b2b idle gap: got busy=%b want 0", busy);
    end
    do_op("b2b_second", 8'hF0, 8'h0F, 1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_reset_mid();
    int d0;
    do_op("pre_reset", 8'd9, 8'd9, 1'b0, 1'b1, 1'b1, 0, 0);
    a = 8'd13; b = 8'd11; signed_en = 0; acc_en = 1; acc_clr = 0; start = 1;
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, ovf} !== 3'b000 || prod !== 16'd0 || acc !== 20'd0) begin
      bad++;
      $display("FAIL mid_reset outputs: got busy=%b done=%b ovf=%b prod=%h acc=%h want 0",
               busy, done, ovf, prod, acc);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    total++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      bad++; $display("FAIL mid_reset abandon: got done=%0d busy=%b want 0/0",
                      done_cnt - d0, busy);
    end
    m_acc = '0;
    m_ovf = 1'b0;
    do_op("post_reset", 8'd13, 8'd11, 1'b0, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic test_sweep_w12();
    logic [11:0] ta, tb;
    logic        ts;
    logic [23:0] exp_p;
    int          n;
    for (int t = 0; t < 24; t++) begin
      ta = 12'($urandom_range(0, 4095));
      tb = 12'($urandom_range(0, 4095));
      ts = 1'($urandom_range(0, 1));
      if (t == 0) begin ta = 12'h800; tb = 12'h800; ts = 1'b1; end
      if (t == 1) begin ta = 12'hFFF; tb = 12'hFFF; ts = 1'b0; end
      if (t == 2) begin ta = 12'hFFF; tb = 12'h7FF; ts = 1'b1; end
      a12 = ta; b12 = tb; signed12 = ts; start12 = 1'b1;
      if (ts) q12.push_back(24'(longint'($signed(ta)) * longint'($signed(tb))));
      else    q12.push_back(24'(longint'(ta) * longint'(tb)));
      @(posedge clk); #1;
      start12 = 1'b0;
      n = 0;
      while (done12 !== 1'b1 && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      exp_p = q12.pop_front();
      total++;
      if (n != 17) begin
        bad++; $display("FAIL w12 latency: got %0d edges want 17", n);
      end
      total++;
      if (prod12 !== exp_p) begin
        bad++; $display("FAIL w12 prod a=%h b=%h s=%b: got %h want %h", ta, tb, ts, prod12, exp_p);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sweep_s8();
    logic [7:0]  ta, tb;
    logic        ts;
    logic [15:0] exp_p;
    int          n;
    for (int t = 0; t < 40; t++) begin
      ta = 8'($urandom_range(0, 255));
      tb = 8'($urandom_range(0, 255));
      ts = 1'($urandom_range(0, 1));
      if (t == 0) begin ta = 8'h80; tb = 8'h80; ts = 1'b1; end
      if (t == 1) begin ta = 8'hFF; tb = 8'hFF; ts = 1'b0; end
      a88 = ta; b88 = tb; signed88 = ts; start88 = 1'b1;
      q88.push_back(ref_prod8(ta, tb, ts));
      @(posedge clk); #1;
      start88 = 1'b0;
      n = 0;
      while (done88 !== 1'b1 && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      exp_p = q88.pop_front();
      total++;
      if (n != 2) begin
        bad++; $display("FAIL s8 latency: got %0d edges want 2", n);
      end
      total++;
      if (prod88 !== exp_p) begin
        bad++; $display("FAIL s8 prod a=%h b=%h s=%b: got %h want %h", ta, tb, ts, prod88, exp_p);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_accumulate();
    test_handshake();
    test_reset_mid();
    test_sweep_w12();
    test_sweep_s8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
